// File: rtl/hamming_decoder.sv
// Hamming(12,8) SEC decoder with even parity, parity bits at positions 1,2,4,8, and one register stage.
// Define DECODER_ERR_COUNT_EN to add the saturating err_count port.
module hamming_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [11:0] D,
`ifdef DECODER_ERR_COUNT_EN
  output logic [15:0] err_count,
`endif
  output logic        out_valid,
  output logic [7:0]  decodedCode,
  output logic [3:0]  syndrome,
  output logic        corrected,
  output logic        uncorrectable
);

  logic [3:0]  syn_d;
  logic [11:0] flip_d;
  logic [11:0] cw_d;
  logic [7:0]  data_d;
  logic        corr_d;
  logic        unc_d;

  logic        out_valid_q;
  logic [7:0]  data_q;
  logic [3:0]  syn_q;
  logic        corr_q;
  logic        unc_q;

  // D[i] holds Hamming position i+1.
  always_comb begin
    syn_d[0] = D[0] ^ D[2] ^ D[4] ^ D[6] ^ D[8] ^ D[10];
    syn_d[1] = D[1] ^ D[2] ^ D[5] ^ D[6] ^ D[9] ^ D[10];
    syn_d[2] = D[3] ^ D[4] ^ D[5] ^ D[6] ^ D[11];
    syn_d[3] = D[7] ^ D[8] ^ D[9] ^ D[10] ^ D[11];
  end

  // Syndromes 13..15 address no position, so the mask stays clear for them.
  always_comb begin
    flip_d = '0;
    for (int p = 1; p <= 12; p++)
      if (syn_d == 4'(p)) flip_d[p-1] = 1'b1;
  end

  always_comb begin
    cw_d   = D ^ flip_d;
    data_d = {cw_d[11], cw_d[10], cw_d[9], cw_d[8], cw_d[6], cw_d[5], cw_d[4], cw_d[2]};
    corr_d = (syn_d != 4'd0) && (syn_d <= 4'd12);
    unc_d  = (syn_d >= 4'd13);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      syn_q       <= '0;
      corr_q      <= 1'b0;
      unc_q       <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        data_q <= data_d;
        syn_q  <= syn_d;
        corr_q <= corr_d;
        unc_q  <= unc_d;
      end
    end
  end

`ifdef DECODER_ERR_COUNT_EN
  logic [15:0] err_cnt_q;
  logic [15:0] err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_valid && (corr_d || unc_d) && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

  assign out_valid     = out_valid_q;
  assign decodedCode   = data_q;
  assign syndrome      = syn_q;
  assign corrected     = corr_q;
  assign uncorrectable = unc_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard bench for hamming_decoder: expectations queued at drive time, popped as words emerge.
// Honours DECODER_ERR_COUNT_EN when the design is built with it.
module tb_hamming_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] D;
  logic        out_valid;
  logic [7:0]  decodedCode;
  logic [3:0]  syndrome;
  logic        corrected;
  logic        uncorrectable;
`ifdef DECODER_ERR_COUNT_EN
  logic [15:0] err_count;
  int          err_model;
`endif

  typedef struct {
    logic [7:0] d;
    logic [3:0] s;
    logic       c;
    logic       u;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_tests;
  int   n_fail;

  hamming_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .D             (D),
`ifdef DECODER_ERR_COUNT_EN
    .err_count     (err_count),
`endif
    .out_valid     (out_valid),
    .decodedCode   (decodedCode),
    .syndrome      (syndrome),
    .corrected     (corrected),
    .uncorrectable (uncorrectable)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Place a byte in positions 3,5,6,7,9,10,11,12 and set parity bits so the XOR of set positions is zero.
  function automatic logic [11:0] encode(input logic [7:0] b);
    logic [11:0] cw;
    logic [3:0]  s;
    cw = '0;
    {cw[11], cw[10], cw[9], cw[8], cw[6], cw[5], cw[4], cw[2]} = b;
    s = '0;
    for (int p = 1; p <= 12; p++)
      if (cw[p-1]) s = s ^ 4'(p);
    cw[0] = s[0];
    cw[1] = s[1];
    cw[3] = s[2];
    cw[7] = s[3];
    return cw;
  endfunction

  task automatic drive(input logic [11:0] d, input logic [7:0] ed, input logic [3:0] es,
                       input logic ec, input logic eu);
    exp_t e;
    @(negedge clk);
    D        = d;
    in_valid = 1'b1;
    e.d = ed; e.s = es; e.c = ec; e.u = eu;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      D        = 12'(($urandom));
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      D        = 12'b101100001101;
      @(negedge clk);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  // Monitor: sample the controls at the edge, check the registered outputs just after it.
  always @(posedge clk) begin
    logic s_rst;
    logic s_vld;
    exp_t e;
    s_rst = rst_n;
    s_vld = in_valid;
    #1;
    if (!s_rst) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(decodedCode), 32'd0);
      chk("rst_syn", 32'(syndrome), 32'd0);
      chk("rst_flags", 32'({corrected, uncorrectable}), 32'd0);
      last_exp = '{8'd0, 4'd0, 1'b0, 1'b0};
`ifdef DECODER_ERR_COUNT_EN
      err_model = 0;
`endif
    end else begin
      chk("out_valid", 32'(out_valid), 32'(s_vld));
      if (s_vld) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          last_exp = e;
`ifdef DECODER_ERR_COUNT_EN
          if ((e.c || e.u) && err_model < 65535) err_model++;
`endif
        end
      end
      chk(s_vld ? "data" : "hold_data", 32'(decodedCode), 32'(last_exp.d));
      chk(s_vld ? "syn" : "hold_syn", 32'(syndrome), 32'(last_exp.s));
      chk(s_vld ? "corrected" : "hold_corrected", 32'(corrected), 32'(last_exp.c));
      chk(s_vld ? "uncorrectable" : "hold_unc", 32'(uncorrectable), 32'(last_exp.u));
    end
`ifdef DECODER_ERR_COUNT_EN
    chk("err_count", 32'(err_count), 32'(err_model));
`endif
  end

  initial begin
    logic [7:0]  b;
    logic [11:0] cw;
    int          pos;
    n_tests  = 0;
    n_fail   = 0;
    last_exp = '{8'd0, 4'd0, 1'b0, 1'b0};
`ifdef DECODER_ERR_COUNT_EN
    err_model = 0;
`endif
    rst_n    = 1'b0;
    in_valid = 1'b1;
    D        = 12'b101100001101;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    drive(12'b101000001101, 8'hA1, 4'd0,  1'b0, 1'b0);
    drive(12'b101100001101, 8'hA1, 4'd9,  1'b1, 1'b0);
    drive(12'b100000010011, 8'hA2, 4'd10, 1'b1, 1'b0);
    drive(12'b101000001100, 8'hA1, 4'd1,  1'b1, 1'b0);
    drive(12'b101100000101, 8'hB1, 4'd13, 1'b0, 1'b1);
    idle(3);

    // 16 back-to-back words, each clean or with one flipped bit anywhere in the codeword.
    for (int i = 0; i < 16; i++) begin
      b   = 8'($urandom);
      cw  = encode(b);
      pos = (i < 13) ? i : $urandom_range(0, 12);
      if (pos != 0) cw[pos-1] = ~cw[pos-1];
      drive(cw, b, 4'(pos), pos != 0, 1'b0);
    end
    idle(4);

    do_reset(2);
    drive(12'b100000010011, 8'hA2, 4'd10, 1'b1, 1'b0);
    drive(12'b101000001101, 8'hA1, 4'd0,  1'b0, 1'b0);
    idle(3);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
